game_controller: RTL and testbench
==================================

# game_controller

Match sequencer for Pong. It owns the game flow around the ball, paddles and score counter:
- holds the ball at centre for serves;
- enables ball motion during rallies;
- detects points from score increments, pauses between points;
- declares a winner at a configurable score and clears the scores for a new game.

It sits between the start button / video frame timing and the ball logic and score counter, in the same clock domain.

## Interface
Parameters:
- WIN_SCORE, 9: score that ends the game; legal range 1..9.
- SERVE_DELAY_FRAMES, 60: frames the ball is held at centre before a serve; 0..255.
- POINT_PAUSE_FRAMES, 90: frames of pause after a point; 0..255.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low; one clock, synchronous reset (active-low).
- frame_tick  in  1  one-cycle pulse per video frame.
- start_button  in  1  debounced level, 1 = pressed.
- score_player_one  in  4  from score counter (0..9).
- score_player_two  in  4  from score counter (0..9).
- score_clear_n  out  1  drives score counter reset input; 0 clears scores.
- ball_reset  out  1  1 = hold ball at centre.
- ball_enable  out  1  1 = ball may move.
- serve_dir  out  1  0 = serve toward player one (left), 1 = toward player two (right).
- game_over  out  1  1 in OVER.
- winner  out  2  00 none, 01 player one, 10 player two.
- game_state  out  3  current FSM state, for display/debug.

## Operation
- Start edge: start_edge = start_button & ~start_q. start_q is registered every cycle and resets to 1, so a button held through reset does not start a game.
- Point event: score_player_X > prev_X, using registered previous scores (reset 0, updated every cycle).
  - A decrease (clear) is never a point.
  - If both scores rise in the same cycle, player one wins priority; player two's increment is ignored.
- Point events are acted on only in PLAY. In other states they are ignored, but prev_X still tracks.
- Delay counter: 8-bit.
  - Loaded with the parameter on state entry.
  - Decremented on frame_tick while nonzero.
  - The state exits on the first cycle the counter is 0, so the delay is N frame ticks; N = 0 exits one cycle after entry.

FSM (Moore decode of ball_reset / ball_enable / score_clear_n / game_over from state):
- IDLE (000): score_clear_n = 0, ball_reset = 1, ball_enable = 0.
  - start_edge -> SERVE; load SERVE_DELAY_FRAMES.
- SERVE (001): ball_reset = 1, ball_enable = 0.
  - Counter 0 -> PLAY.
- PLAY (010): ball_reset = 0, ball_enable = 1.
  - Point by player P with new score >= WIN_SCORE -> OVER; winner = P.
  - Other point -> POINT; load POINT_PAUSE_FRAMES.
  - On any point, serve_dir is set toward the player who conceded: P1 scores -> 1, P2 scores -> 0.
- POINT (011): ball_reset = 1, ball_enable = 0.
  - Counter 0 -> SERVE; load SERVE_DELAY_FRAMES.
- OVER (100): ball_reset = 1, ball_enable = 0, game_over = 1; winner held; scores are not cleared.
  - start_edge -> IDLE. A second start_edge is needed to begin play.
- Encodings 101..111: go to IDLE next cycle.
- winner clears to 00 on entry to IDLE.
- serve_dir is otherwise unchanged.

## Timing
- Reset (reset = 0 at a rising edge), values from the next cycle:
  - game_state = IDLE, score_clear_n = 0, ball_reset = 1, ball_enable = 0;
  - serve_dir = 1, game_over = 0, winner = 00;
  - counter = 0, prev scores = 0, start_q = 1.
- Reset mid-game aborts immediately to IDLE; counters are discarded.
- The score counter updates on the falling edge, so scores are stable at the rising edge. Point detection is sampled at the rising edge after the increment; the state changes at that edge.
- Outputs change one cycle after the causing input edge; there is no combinational input-to-output path.
- start_edge and counter expiry in the same cycle: expiry governs SERVE/POINT. start_edge is used only in IDLE/OVER.

## Structure
- Shared package pong_pkg: state encodings (IDLE..OVER), winner codes (WINNER_NONE/ONE/TWO), SCORE_W = 4, FRAME_CNT_W = 8.
- One sub-module, frame_delay_counter: load value + load strobe, frame_tick, done flag.
- The FSM, edge detect and point detect live in game_controller.

## Test plan
1. Reset with start_button held at 1 -> stays IDLE, score_clear_n = 0. Release then press -> SERVE; after 60 frame_ticks -> PLAY, ball_enable = 1.
2. In PLAY, score_player_two 0 -> 1 -> next cycle POINT, serve_dir = 0, ball_reset = 1. After 90 frame_ticks -> SERVE.
3. WIN_SCORE = 3; score_player_one steps to 3 in PLAY -> OVER, game_over = 1, winner = 01. Start press -> IDLE, winner = 00, score_clear_n = 0.
4. Score increment while in SERVE -> no state change, serve_dir unchanged. Later PLAY ignores that stale increment.
5. Both scores increment in the same PLAY cycle -> player one's point taken, serve_dir = 1.
6. SERVE_DELAY_FRAMES = 0 -> SERVE lasts exactly one cycle. Reset asserted in POINT mid-count -> IDLE next cycle with all reset values.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and widths for the Pong match sequencer.
package pong_pkg;

  localparam int SCORE_W     = 4;
  localparam int FRAME_CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    SERVE = 3'b001,
    PLAY  = 3'b010,
    POINT = 3'b011,
    OVER  = 3'b100
  } state_t;

  typedef enum logic [1:0] {
    WINNER_NONE = 2'b00,
    WINNER_ONE  = 2'b01,
    WINNER_TWO  = 2'b10
  } winner_t;

endpackage

// File: rtl/game_controller_frame_delay_counter.sv
// Frame-tick down counter: load on strobe, count ticks down to zero, flag zero.
module frame_delay_counter
  import pong_pkg::*;
(
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic                   i_load,
  input  logic [FRAME_CNT_W-1:0] i_load_value,
  input  logic                   i_frame_tick,
  output logic                   o_done
);

  logic [FRAME_CNT_W-1:0] r_count;

  // A load wins over a tick arriving in the same cycle, so a full N ticks always follow entry.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_frame_tick && (r_count != '0)) begin
      r_count <= r_count - FRAME_CNT_W'(1);
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/game_controller.sv
// Pong match sequencer: serve hold, rally enable, point detection, pause and winner.
module game_controller
  import pong_pkg::*;
#(
  parameter int WIN_SCORE          = 9,
  parameter int SERVE_DELAY_FRAMES = 60,
  parameter int POINT_PAUSE_FRAMES = 90
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start_button,
  input  logic [SCORE_W-1:0] score_player_one,
  input  logic [SCORE_W-1:0] score_player_two,
  output logic               score_clear_n,
  output logic               ball_reset,
  output logic               ball_enable,
  output logic               serve_dir,
  output logic               game_over,
  output logic [1:0]         winner,
  output logic [2:0]         game_state
);

  localparam logic [SCORE_W-1:0]     L_WIN_SCORE   = SCORE_W'(WIN_SCORE);
  localparam logic [FRAME_CNT_W-1:0] L_SERVE_DELAY = FRAME_CNT_W'(SERVE_DELAY_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] L_POINT_PAUSE = FRAME_CNT_W'(POINT_PAUSE_FRAMES);

  state_t               r_state;
  state_t               w_next_state;
  logic                 r_start_q;
  logic [SCORE_W-1:0]   r_prev_one;
  logic [SCORE_W-1:0]   r_prev_two;
  logic                 r_serve_dir;
  winner_t              r_winner;

  logic                 w_start_edge;
  logic                 w_p1_point;
  logic                 w_p2_point;
  logic                 w_any_point;
  logic                 w_win;
  logic                 w_load;
  logic [FRAME_CNT_W-1:0] w_load_value;
  logic                 w_cnt_done;

  // start_q resets high so a button held through reset never counts as a press.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_start_q  <= 1'b1;
      r_prev_one <= '0;
      r_prev_two <= '0;
    end else begin
      r_start_q  <= start_button;
      r_prev_one <= score_player_one;
      r_prev_two <= score_player_two;
    end
  end

  assign w_start_edge = start_button & ~r_start_q;
  assign w_p1_point   = (score_player_one > r_prev_one);
  assign w_p2_point   = (score_player_two > r_prev_two) & ~w_p1_point;
  assign w_any_point  = w_p1_point | w_p2_point;
  assign w_win        = w_p1_point ? (score_player_one >= L_WIN_SCORE)
                                   : (score_player_two >= L_WIN_SCORE);

  // State register
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_start_edge) w_next_state = SERVE;
      SERVE:   if (w_cnt_done)   w_next_state = PLAY;
      PLAY:    if (w_any_point)  w_next_state = w_win ? OVER : POINT;
      POINT:   if (w_cnt_done)   w_next_state = SERVE;
      OVER:    if (w_start_edge) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Moore output decode
  always_comb begin
    score_clear_n = 1'b1;
    ball_reset    = 1'b1;
    ball_enable   = 1'b0;
    game_over     = 1'b0;
    case (r_state)
      IDLE:    score_clear_n = 1'b0;
      PLAY: begin
        ball_reset  = 1'b0;
        ball_enable = 1'b1;
      end
      OVER:    game_over = 1'b1;
      default: ;
    endcase
  end

  // Delay is armed only on entry into a timed state, never while remaining in it.
  always_comb begin
    w_load       = 1'b0;
    w_load_value = L_SERVE_DELAY;
    if (w_next_state != r_state) begin
      if (w_next_state == SERVE) begin
        w_load       = 1'b1;
        w_load_value = L_SERVE_DELAY;
      end else if (w_next_state == POINT) begin
        w_load       = 1'b1;
        w_load_value = L_POINT_PAUSE;
      end
    end
  end

  frame_delay_counter u_delay (
    .i_clock      (clock),
    .i_reset_n    (reset),
    .i_load       (w_load),
    .i_load_value (w_load_value),
    .i_frame_tick (frame_tick),
    .o_done       (w_cnt_done)
  );

  // Serve goes toward whoever conceded; winner latches on the winning point.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_serve_dir <= 1'b1;
      r_winner    <= WINNER_NONE;
    end else begin
      if ((r_state == PLAY) && w_p1_point) begin
        r_serve_dir <= 1'b1;
      end else if ((r_state == PLAY) && w_p2_point) begin
        r_serve_dir <= 1'b0;
      end
      if (w_next_state == IDLE) begin
        r_winner <= WINNER_NONE;
      end else if ((r_state == PLAY) && (w_next_state == OVER)) begin
        r_winner <= w_p1_point ? WINNER_ONE : WINNER_TWO;
      end
    end
  end

  assign serve_dir  = r_serve_dir;
  assign winner     = r_winner;
  assign game_state = r_state;

endmodule

// File: tb/tb_game_controller.sv
// Scoreboard bench for game_controller: two instances, one with default timing and a
// low win score, one with zero serve/pause delays.
module tb_game_controller;
  import pong_pkg::*;

  localparam int VW = 10;
  localparam int QW = 16 + VW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // instance A: WIN 3, SERVE 60, PAUSE 90
  logic       a_rst, a_tick, a_start;
  logic [3:0] a_s1, a_s2;
  logic       a_clr, a_brst, a_ben, a_sd, a_over;
  logic [1:0] a_win;
  logic [2:0] a_gst;

  // instance B: WIN 2, SERVE 0, PAUSE 0
  logic       b_rst, b_tick, b_start;
  logic [3:0] b_s1, b_s2;
  logic       b_clr, b_brst, b_ben, b_sd, b_over;
  logic [1:0] b_win;
  logic [2:0] b_gst;

  game_controller #(.WIN_SCORE(3), .SERVE_DELAY_FRAMES(60), .POINT_PAUSE_FRAMES(90)) u_dut_a (
    .clock(clk), .reset(a_rst), .frame_tick(a_tick), .start_button(a_start),
    .score_player_one(a_s1), .score_player_two(a_s2),
    .score_clear_n(a_clr), .ball_reset(a_brst), .ball_enable(a_ben), .serve_dir(a_sd),
    .game_over(a_over), .winner(a_win), .game_state(a_gst)
  );

  game_controller #(.WIN_SCORE(2), .SERVE_DELAY_FRAMES(0), .POINT_PAUSE_FRAMES(0)) u_dut_b (
    .clock(clk), .reset(b_rst), .frame_tick(b_tick), .start_button(b_start),
    .score_player_one(b_s1), .score_player_two(b_s2),
    .score_clear_n(b_clr), .ball_reset(b_brst), .ball_enable(b_ben), .serve_dir(b_sd),
    .game_over(b_over), .winner(b_win), .game_state(b_gst)
  );

  // ---------------- scoreboard ----------------
  logic [QW-1:0] exp_q_a[$];
  logic [QW-1:0] exp_q_b[$];
  int n_checks = 0;
  int n_pass   = 0;

  // Expected output vector from the state table: {state, clear_n, ball_reset, ball_enable, serve_dir, game_over, winner}
  function automatic logic [VW-1:0] model(input logic [2:0] st, input logic sd, input logic [1:0] w);
    logic clr_n, brst, ben, over;
    clr_n = (st != 3'b000);
    brst  = (st != 3'b010);
    ben   = (st == 3'b010);
    over  = (st == 3'b100);
    return {st, clr_n, brst, ben, sd, over, w};
  endfunction

  task automatic expect_ev(input int id, input logic [2:0] st, input logic sd,
                           input logic [1:0] w, input int dcyc);
    logic [QW-1:0] e;
    e = {16'(int'(cyc) + dcyc), model(st, sd, w)};
    if (id == 0) exp_q_a.push_back(e);
    else         exp_q_b.push_back(e);
  endtask

  task automatic observe(input int id, input logic [VW-1:0] cur);
    logic [QW-1:0] e;
    bit have;
    have = 1'b0;
    e    = '0;
    if (id == 0 && exp_q_a.size() > 0) begin
      e = exp_q_a.pop_front(); have = 1'b1;
    end else if (id == 1 && exp_q_b.size() > 0) begin
      e = exp_q_b.pop_front(); have = 1'b1;
    end
    n_checks++;
    if (!have) begin
      $display("FAIL unexpected_change inst=%0d cyc=%0d got=%b required=no change", id, cyc, cur);
    end else begin
      if (e[VW-1:0] === cur) n_pass++;
      else $display("FAIL outputs inst=%0d cyc=%0d got=%b required=%b", id, cyc, cur, e[VW-1:0]);
      n_checks++;
      if (e[QW-1:VW] === 16'(cyc)) n_pass++;
      else $display("FAIL timing inst=%0d state=%b got_cyc=%0d required_cyc=%0d",
                    id, cur[VW-1:VW-3], cyc, e[QW-1:VW]);
    end
  endtask

  // Monitor: every change of a DUT's output vector is one presented event.
  logic [VW-1:0] last_a = 'x;
  logic [VW-1:0] last_b = 'x;
  always @(negedge clk) begin
    logic [VW-1:0] cur_a, cur_b;
    cur_a = {a_gst, a_clr, a_brst, a_ben, a_sd, a_over, a_win};
    cur_b = {b_gst, b_clr, b_brst, b_ben, b_sd, b_over, b_win};
    if (cur_a !== last_a) begin
      observe(0, cur_a);
      last_a = cur_a;
    end
    if (cur_b !== last_b) begin
      observe(1, cur_b);
      last_b = cur_b;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_ticks_a(input int n);
    for (int i = 0; i < n; i++) begin
      a_tick = 1'b1; step();
      a_tick = 1'b0; step();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    a_rst = 1'b0; a_tick = 1'b0; a_start = 1'b1; a_s1 = '0; a_s2 = '0;
    b_rst = 1'b0; b_tick = 1'b0; b_start = 1'b0; b_s1 = '0; b_s2 = '0;
    expect_ev(0, IDLE, 1'b1, WINNER_NONE, 1);
    expect_ev(1, IDLE, 1'b1, WINNER_NONE, 1);
    repeat (3) step();
    a_rst = 1'b1; b_rst = 1'b1;
    repeat (4) step();                 // start held through reset: no game
    a_start = 1'b0; step();

    // Instance A, game 1
    a_start = 1'b1; expect_ev(0, SERVE, 1'b1, WINNER_NONE, 1); step(); a_start = 1'b0;
    expect_ev(0, PLAY, 1'b1, WINNER_NONE, 120); frame_ticks_a(60);
    repeat (3) step();
    a_s2 = 4'd1; expect_ev(0, POINT, 1'b0, WINNER_NONE, 1); step();
    expect_ev(0, SERVE, 1'b0, WINNER_NONE, 180); frame_ticks_a(90);
    a_s1 = 4'd1; expect_ev(0, PLAY, 1'b0, WINNER_NONE, 121); step(); frame_ticks_a(60);
    repeat (5) step();                 // stale increment from SERVE must stay ignored
    a_s1 = 4'd2; a_s2 = 4'd2; expect_ev(0, POINT, 1'b1, WINNER_NONE, 1); step();
    expect_ev(0, SERVE, 1'b1, WINNER_NONE, 180); frame_ticks_a(90);
    expect_ev(0, PLAY, 1'b1, WINNER_NONE, 120); frame_ticks_a(60);
    repeat (2) step();
    a_s1 = 4'd3; expect_ev(0, OVER, 1'b1, WINNER_ONE, 1); step();
    repeat (4) step();
    a_s1 = 4'd0; a_s2 = 4'd0; repeat (2) step();
    a_start = 1'b1; expect_ev(0, IDLE, 1'b1, WINNER_NONE, 1); step(); a_start = 1'b0;
    repeat (3) step();

    // Instance A, game 2: start edge in SERVE ignored, reset mid-pause
    a_start = 1'b1; expect_ev(0, SERVE, 1'b1, WINNER_NONE, 1); step();
    a_start = 1'b0; step();
    a_start = 1'b1; step();
    a_start = 1'b0;
    expect_ev(0, PLAY, 1'b1, WINNER_NONE, 120); frame_ticks_a(60);
    repeat (2) step();
    a_s2 = 4'd1; expect_ev(0, POINT, 1'b0, WINNER_NONE, 1); step();
    frame_ticks_a(10);
    a_rst = 1'b0; expect_ev(0, IDLE, 1'b1, WINNER_NONE, 1); step(); a_rst = 1'b1;
    repeat (3) step();
    a_start = 1'b1; expect_ev(0, SERVE, 1'b1, WINNER_NONE, 1); step(); a_start = 1'b0;
    expect_ev(0, PLAY, 1'b1, WINNER_NONE, 120); frame_ticks_a(60);
    repeat (3) step();

    // Instance B: zero delays, win at 2
    b_start = 1'b1;
    expect_ev(1, SERVE, 1'b1, WINNER_NONE, 1);
    expect_ev(1, PLAY,  1'b1, WINNER_NONE, 2);
    step(); b_start = 1'b0; repeat (3) step();
    b_s1 = 4'd1;
    expect_ev(1, POINT, 1'b1, WINNER_NONE, 1);
    expect_ev(1, SERVE, 1'b1, WINNER_NONE, 2);
    expect_ev(1, PLAY,  1'b1, WINNER_NONE, 3);
    repeat (4) step();
    b_s2 = 4'd1;
    expect_ev(1, POINT, 1'b0, WINNER_NONE, 1);
    expect_ev(1, SERVE, 1'b0, WINNER_NONE, 2);
    expect_ev(1, PLAY,  1'b0, WINNER_NONE, 3);
    repeat (4) step();
    b_s2 = 4'd2; expect_ev(1, OVER, 1'b0, WINNER_TWO, 1); repeat (3) step();
    b_s1 = 4'd0; b_s2 = 4'd0; repeat (2) step();
    b_start = 1'b1; expect_ev(1, IDLE, 1'b0, WINNER_NONE, 1); step(); b_start = 1'b0; step();
    b_start = 1'b1;
    expect_ev(1, SERVE, 1'b0, WINNER_NONE, 1);
    expect_ev(1, PLAY,  1'b0, WINNER_NONE, 2);
    step(); b_start = 1'b0; repeat (5) step();

    // ---------------- report ----------------
    while (exp_q_a.size() > 0) begin
      logic [QW-1:0] e;
      e = exp_q_a.pop_front();
      n_checks++;
      $display("FAIL missing_event inst=0 got=none required=%b at_cyc=%0d", e[VW-1:0], e[QW-1:VW]);
    end
    while (exp_q_b.size() > 0) begin
      logic [QW-1:0] e;
      e = exp_q_b.pop_front();
      n_checks++;
      $display("FAIL missing_event inst=1 got=none required=%b at_cyc=%0d", e[VW-1:0], e[QW-1:VW]);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
